// File: rtl/vec_issue_ctrl.sv
// Vector-instruction issue/commit/retire tracker between the scalar pipeline and a vector coprocessor.
// Optional build macro VEC_ISSUE_ILLEGAL_AUTOFLUSH_EN: an illegal retire also flushes younger work.
module vec_issue_ctrl #(
  parameter  int unsigned NrInsnID = 4,
  parameter  int unsigned CtxWidth = 32,
  localparam int unsigned IdW      = $clog2(NrInsnID)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sc_valid_i,
  output logic                sc_ready_o,
  input  logic [31:0]         sc_insn_i,
  input  logic [CtxWidth-1:0] sc_ctx_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [31:0]         insn_o,
  output logic [IdW-1:0]      insn_id_o,
  output logic [CtxWidth-1:0] vec_context_o,
  input  logic                commit_ok_i,
  output logic                insn_can_commit_o,
  output logic [IdW-1:0]      insn_can_commit_id_o,
  input  logic                done_i,
  input  logic [IdW-1:0]      done_insn_id_i,
  input  logic                illegal_insn_i,
  input  logic                flush_i,
  output logic                flush_o,
  output logic                retire_valid_o,
  output logic [IdW-1:0]      retire_id_o,
  output logic                retire_illegal_o
);

  typedef enum logic [2:0] {ST_FREE, ST_PEND, ST_SENT, ST_PERM, ST_DONE} ent_e;

  localparam logic [IdW:0] FullCnt = (IdW+1)'(NrInsnID);

  ent_e                  state_q [NrInsnID];
  ent_e                  state_d [NrInsnID];
  logic [NrInsnID-1:0]   ill_q, ill_d;
  logic [IdW-1:0]        head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [IdW:0]          count_q, count_d, squash_cnt;

  logic                  valid_q, valid_d;
  logic [31:0]           insn_q;
  logic [IdW-1:0]        id_q;
  logic [CtxWidth-1:0]   ctx_q;
  logic                  cc_q, ret_q, ret_ill_q, flush_q;
  logic [IdW-1:0]        cc_id_q, ret_id_q;

  logic full, send, done_hit, head_is_done, retire, retire_ill, flush_any, can_commit, accept;

  assign full         = (count_q == FullCnt);
  assign send         = valid_q && ready_i;
  assign done_hit     = done_i && (state_q[done_insn_id_i] == ST_PERM);
  assign head_is_done = (state_q[head_q] == ST_DONE);
  // A done arriving for the head entry retires it on the same edge (one-cycle latency).
  assign retire       = head_is_done || (done_hit && (done_insn_id_i == head_q));
  assign retire_ill   = head_is_done ? ill_q[head_q] : illegal_insn_i;
`ifdef VEC_ISSUE_ILLEGAL_AUTOFLUSH_EN
  assign flush_any    = flush_i || (retire && retire_ill);
`else
  assign flush_any    = flush_i;
`endif
  assign can_commit   = commit_ok_i && (state_q[commit_q] == ST_SENT) && !flush_any;
  assign sc_ready_o   = !full && !flush_any && (!valid_q || ready_i);
  assign accept       = sc_valid_i && sc_ready_o;

  always_comb begin
    squash_cnt = '0;
    for (int i = 0; i < NrInsnID; i++) begin
      state_d[i] = state_q[i];
      if ((state_q[i] == ST_PEND) || (state_q[i] == ST_SENT)) squash_cnt = squash_cnt + 1'b1;
    end
    ill_d = ill_q;

    if (send) state_d[id_q] = ST_SENT;
    if (can_commit) state_d[commit_q] = ST_PERM;
    if (done_hit) begin
      state_d[done_insn_id_i] = ST_DONE;
      ill_d[done_insn_id_i]   = illegal_insn_i;
    end
    if (retire) begin
      state_d[head_q] = ST_FREE;
      ill_d[head_q]   = 1'b0;
    end
    // Speculative work (not yet permitted) is dropped; permitted/done entries survive.
    if (flush_any) begin
      for (int i = 0; i < NrInsnID; i++) begin
        if ((state_q[i] == ST_PEND) || (state_q[i] == ST_SENT)) state_d[i] = ST_FREE;
      end
    end
    if (accept) state_d[tail_q] = ST_PEND;

    head_d   = retire ? head_q + 1'b1 : head_q;
    commit_d = can_commit ? commit_q + 1'b1 : commit_q;
    tail_d   = flush_any ? commit_q : (accept ? tail_q + 1'b1 : tail_q);
    count_d  = count_q + (IdW+1)'(accept) - (IdW+1)'(retire) - (flush_any ? squash_cnt : '0);

    valid_d = valid_q;
    if (flush_any)   valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (send)   valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrInsnID; i++) state_q[i] <= ST_FREE;
      ill_q     <= '0;
      head_q    <= '0;
      commit_q  <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      insn_q    <= '0;
      id_q      <= '0;
      ctx_q     <= '0;
      cc_q      <= 1'b0;
      cc_id_q   <= '0;
      ret_q     <= 1'b0;
      ret_id_q  <= '0;
      ret_ill_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NrInsnID; i++) state_q[i] <= state_d[i];
      ill_q    <= ill_d;
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (accept) begin
        insn_q <= sc_insn_i;
        id_q   <= tail_q;
        ctx_q  <= sc_ctx_i;
      end
      cc_q      <= can_commit;
      cc_id_q   <= can_commit ? commit_q : cc_id_q;
      ret_q     <= retire;
      ret_id_q  <= retire ? head_q : ret_id_q;
      ret_ill_q <= retire && retire_ill;
      flush_q   <= flush_any;
    end
  end

  assign valid_o              = valid_q;
  assign insn_o               = insn_q;
  assign insn_id_o            = id_q;
  assign vec_context_o        = ctx_q;
  assign insn_can_commit_o    = cc_q;
  assign insn_can_commit_id_o = cc_id_q;
  assign retire_valid_o       = ret_q;
  assign retire_id_o          = ret_id_q;
  assign retire_illegal_o     = ret_ill_q;
  assign flush_o              = flush_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed scoreboard bench for vec_issue_ctrl: issue, commit and retire expectations are queued and popped as the DUT produces them.
module tb_vec_issue_ctrl;
  localparam int NrInsnID = 4;
  localparam int CtxWidth = 32;
  localparam int IdW      = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                sc_valid_i = 1'b0;
  logic                sc_ready_o;
  logic [31:0]         sc_insn_i = '0;
  logic [CtxWidth-1:0] sc_ctx_i = '0;
  logic                valid_o;
  logic                ready_i = 1'b0;
  logic [31:0]         insn_o;
  logic [IdW-1:0]      insn_id_o;
  logic [CtxWidth-1:0] vec_context_o;
  logic                commit_ok_i = 1'b0;
  logic                insn_can_commit_o;
  logic [IdW-1:0]      insn_can_commit_id_o;
  logic                done_i = 1'b0;
  logic [IdW-1:0]      done_insn_id_i = '0;
  logic                illegal_insn_i = 1'b0;
  logic                flush_i = 1'b0;
  logic                flush_o;
  logic                retire_valid_o;
  logic [IdW-1:0]      retire_id_o;
  logic                retire_illegal_o;

  always #5 clk_i = ~clk_i;

  vec_issue_ctrl #(.NrInsnID(NrInsnID), .CtxWidth(CtxWidth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sc_valid_i(sc_valid_i), .sc_ready_o(sc_ready_o), .sc_insn_i(sc_insn_i), .sc_ctx_i(sc_ctx_i),
    .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .insn_id_o(insn_id_o),
    .vec_context_o(vec_context_o),
    .commit_ok_i(commit_ok_i), .insn_can_commit_o(insn_can_commit_o),
    .insn_can_commit_id_o(insn_can_commit_id_o),
    .done_i(done_i), .done_insn_id_i(done_insn_id_i), .illegal_insn_i(illegal_insn_i),
    .flush_i(flush_i), .flush_o(flush_o),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o), .retire_illegal_o(retire_illegal_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]         q_insn [$];
  logic [IdW-1:0]      q_id   [$];
  logic [CtxWidth-1:0] q_ctx  [$];
  logic [IdW-1:0]      q_cc   [$];
  logic [IdW:0]        q_ret  [$];
  logic                exp_flush = 1'b0;
  logic [IdW-1:0]      x_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake is judged just before the edge; registered pulses just after it.
  task automatic tick();
    logic [31:0] ei;
    logic [IdW-1:0] eid;
    logic [CtxWidth-1:0] ec;
    logic [IdW:0] er;
    #1;
    if (valid_o && ready_i) begin
      if (q_id.size() == 0) chk("issue_unexpected", 64'(1), 64'(0));
      else begin
        ei = q_insn.pop_front(); eid = q_id.pop_front(); ec = q_ctx.pop_front();
        chk("insn_o", 64'(insn_o), 64'(ei));
        chk("insn_id_o", 64'(insn_id_o), 64'(eid));
        chk("vec_context_o", 64'(vec_context_o), 64'(ec));
      end
    end
    @(posedge clk_i); #1;
    chk("flush_o", 64'(flush_o), 64'(exp_flush));
    exp_flush = 1'b0;
    if (insn_can_commit_o) begin
      if (q_cc.size() == 0) chk("can_commit_unexpected", 64'(1), 64'(0));
      else begin
        eid = q_cc.pop_front();
        chk("can_commit_id", 64'(insn_can_commit_id_o), 64'(eid));
      end
    end
    if (retire_valid_o) begin
      if (q_ret.size() == 0) chk("retire_unexpected", 64'(1), 64'(0));
      else begin
        er = q_ret.pop_front();
        chk("retire_id", 64'(retire_id_o), 64'(er[IdW-1:0]));
        chk("retire_illegal", 64'(retire_illegal_o), 64'(er[IdW]));
      end
    end
  endtask

  task automatic offer(input logic [31:0] insn, input logic [IdW-1:0] id);
    sc_valid_i = 1'b1;
    sc_insn_i  = insn;
    sc_ctx_i   = insn ^ 32'hA5A5_0000;
    #1;
    chk("sc_ready_accept", 64'(sc_ready_o), 64'(1));
    q_insn.push_back(insn);
    q_id.push_back(id);
    q_ctx.push_back(insn ^ 32'hA5A5_0000);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'(0));
    chk({tag, "_cc"}, 64'(insn_can_commit_o), 64'(0));
    chk({tag, "_cc_id"}, 64'(insn_can_commit_id_o), 64'(0));
    chk({tag, "_ret"}, 64'(retire_valid_o), 64'(0));
    chk({tag, "_ret_id"}, 64'(retire_id_o), 64'(0));
    chk({tag, "_ret_ill"}, 64'(retire_illegal_o), 64'(0));
    chk({tag, "_flush"}, 64'(flush_o), 64'(0));
    chk({tag, "_insn"}, 64'(insn_o), 64'(0));
    chk({tag, "_id"}, 64'(insn_id_o), 64'(0));
    chk({tag, "_ctx"}, 64'(vec_context_o), 64'(0));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    check_outputs_zero("reset");
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single instruction end to end.
    do_reset();
    ready_i = 1'b1; commit_ok_i = 1'b1;
    offer(32'h0000_5057, 2'd0);
    tick();
    sc_valid_i = 1'b0;
    chk("single_valid_up", 64'(valid_o), 64'(1));
    tick();
    chk("single_valid_one_cycle", 64'(valid_o), 64'(0));
    q_cc.push_back(2'd0);
    tick();
    chk("single_cc_pulse", 64'(insn_can_commit_o), 64'(1));
    tick();
    chk("single_cc_drop", 64'(insn_can_commit_o), 64'(0));
    done_i = 1'b1; done_insn_id_i = 2'd0; illegal_insn_i = 1'b0;
    q_ret.push_back({1'b0, 2'd0});
    tick();
    chk("single_retire_latency", 64'(retire_valid_o), 64'(1));
    done_i = 1'b0;
    tick();
    chk("single_retire_drop", 64'(retire_valid_o), 64'(0));
    commit_ok_i = 1'b0;

    // Back-pressure, full tracker, out-of-order done with in-order retire.
    do_reset();
    ready_i = 1'b0;
    offer(32'h1000_0000, 2'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      sc_valid_i = 1'b1; sc_insn_i = 32'h1000_0001;
      #1;
      chk("stall_sc_ready", 64'(sc_ready_o), 64'(0));
      tick();
      chk("stall_insn_stable", 64'(insn_o), 64'(32'h1000_0000));
      chk("stall_id_stable", 64'(insn_id_o), 64'(0));
    end
    ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      offer(32'h1000_0000 + 32'(i), 2'(i));
      tick();
    end
    sc_valid_i = 1'b1; sc_insn_i = 32'h1000_0004;
    #1;
    chk("full_sc_ready", 64'(sc_ready_o), 64'(0));
    tick();
    sc_valid_i = 1'b0;
    commit_ok_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_cc.push_back(2'(i));
      tick();
    end
    commit_ok_i = 1'b0;
    done_i = 1'b1; done_insn_id_i = 2'd2;
    tick();
    chk("ooo_no_retire", 64'(retire_valid_o), 64'(0));
    chk("ooo_still_full", 64'(sc_ready_o), 64'(0));
    done_insn_id_i = 2'd0;
    q_ret.push_back({1'b0, 2'd0});
    tick();
    chk("ooo_retire0", 64'(retire_valid_o), 64'(1));
    done_i = 1'b0;
    #1;
    chk("full_then_retire_ready", 64'(sc_ready_o), 64'(1));
    done_i = 1'b1; done_insn_id_i = 2'd1;
    q_ret.push_back({1'b0, 2'd1});
    q_ret.push_back({1'b0, 2'd2});
    tick();
    done_i = 1'b0;
    tick();
    chk("ooo_retire2", 64'(retire_valid_o), 64'(1));
    tick();
    chk("ooo_no_retire3", 64'(retire_valid_o), 64'(0));
    done_i = 1'b1; done_insn_id_i = 2'd3;
    q_ret.push_back({1'b0, 2'd3});
    tick();
    done_i = 1'b0;

    // Flush squashes unpermitted entries and rewinds tail to the commit pointer.
    for (int i = 0; i < 3; i++) begin
      offer(32'h2000_0000 + 32'(i), 2'(i));
      tick();
    end
    sc_valid_i = 1'b0;
    tick();
    commit_ok_i = 1'b1;
    q_cc.push_back(2'd0);
    tick();
    commit_ok_i = 1'b0;
    flush_i = 1'b1; done_i = 1'b1; done_insn_id_i = 2'd2;
    sc_valid_i = 1'b1; sc_insn_i = 32'h2000_0003;
    #1;
    chk("flush_blocks_accept", 64'(sc_ready_o), 64'(0));
    exp_flush = 1'b1;
    tick();
    chk("flush_drops_valid", 64'(valid_o), 64'(0));
    flush_i = 1'b0; done_i = 1'b0; sc_valid_i = 1'b0;
    tick();
    chk("flush_done_ignored", 64'(retire_valid_o), 64'(0));
    offer(32'h2000_0004, 2'd1);
    tick();
    sc_valid_i = 1'b0;
    tick();
    commit_ok_i = 1'b1;
    q_cc.push_back(2'd1);
    tick();
    commit_ok_i = 1'b0;
    done_i = 1'b1; done_insn_id_i = 2'd0;
    q_ret.push_back({1'b0, 2'd0});
    tick();
    done_insn_id_i = 2'd1;
    q_ret.push_back({1'b0, 2'd1});
    tick();
    done_i = 1'b0;
    tick();

    // Illegal retire with a younger entry still in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer(32'h3000_0000 + 32'(i), 2'(i));
      tick();
    end
    sc_valid_i = 1'b0;
    tick();
    commit_ok_i = 1'b1;
    q_cc.push_back(2'd0);
    tick();
    q_cc.push_back(2'd1);
    tick();
    commit_ok_i = 1'b0;
    done_i = 1'b1; done_insn_id_i = 2'd0; illegal_insn_i = 1'b0;
    q_ret.push_back({1'b0, 2'd0});
    tick();
    done_insn_id_i = 2'd1; illegal_insn_i = 1'b1;
    q_ret.push_back({1'b1, 2'd1});
`ifdef VEC_ISSUE_ILLEGAL_AUTOFLUSH_EN
    exp_flush = 1'b1;
`endif
    tick();
    chk("illegal_retire_flag", 64'(retire_illegal_o), 64'(1));
    done_i = 1'b0; illegal_insn_i = 1'b0;
    commit_ok_i = 1'b1;
`ifndef VEC_ISSUE_ILLEGAL_AUTOFLUSH_EN
    q_cc.push_back(2'd2);
`endif
    tick();
    commit_ok_i = 1'b0;
`ifdef VEC_ISSUE_ILLEGAL_AUTOFLUSH_EN
    x_id = 2'd2;
`else
    done_i = 1'b1; done_insn_id_i = 2'd2;
    q_ret.push_back({1'b0, 2'd2});
    tick();
    done_i = 1'b0;
    x_id = 2'd3;
`endif

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      offer(32'h4000_0000 + 32'(i), 2'(x_id + 2'(i)));
      tick();
    end
    sc_valid_i = 1'b0;
    commit_ok_i = 1'b1;
    q_cc.push_back(x_id);
    tick();
    commit_ok_i = 1'b0;
    chk("pre_reset_issue_q", 64'(q_id.size()), 64'(0));
    chk("pre_reset_cc_q", 64'(q_cc.size()), 64'(0));
    rst_ni = 1'b0; done_i = 1'b1; done_insn_id_i = x_id;
    #1;
    chk("async_reset_valid", 64'(valid_o), 64'(0));
    chk("async_reset_cc", 64'(insn_can_commit_o), 64'(0));
    tick();
    check_outputs_zero("midreset");
    tick();
    rst_ni = 1'b1; done_i = 1'b0;
    tick();
    tick();
    chk("post_reset_no_retire", 64'(retire_valid_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      offer(32'h5000_0000 + 32'(i), 2'(i));
      tick();
    end
    sc_valid_i = 1'b1; sc_insn_i = 32'h5000_0004;
    #1;
    chk("post_reset_count_full", 64'(sc_ready_o), 64'(0));
    sc_valid_i = 1'b0;
    tick();

    chk("end_issue_q_empty", 64'(q_id.size()), 64'(0));
    chk("end_cc_q_empty", 64'(q_cc.size()), 64'(0));
    chk("end_ret_q_empty", 64'(q_ret.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
